// File: rtl/counter4.sv
// counter4: parameterized up/down counter with clear, load, terminal count and wrap pulse.
// Define COUNTER4_SATURATE_EN to hold at the range ends instead of wrapping.
module counter4 #(
   parameter int WIDTH   = 4,
   parameter int MAX_VAL = 2**WIDTH-1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             wrap
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
   logic [WIDTH-1:0] step;
   logic             wrap_next;
   // tc also marks the step that would cross the range boundary
   assign tc = dir ? (out == '0) : (out == MAX);
`ifdef COUNTER4_SATURATE_EN
   assign step      = tc ? out : (dir ? out - 1'b1 : out + 1'b1);
   assign wrap_next = 1'b0;
`else
   assign step      = tc ? (dir ? MAX : '0) : (dir ? out - 1'b1 : out + 1'b1);
   assign wrap_next = tc;
`endif
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         out  <= '0;
         wrap <= 1'b0;
      end else if (load) begin
         out  <= (load_val > MAX) ? MAX : load_val;
         wrap <= 1'b0;
      end else if (en) begin
         out  <= step;
         wrap <= wrap_next;
      end else begin
         wrap <= 1'b0;
      end
   end
endmodule

// File: tb/tb_counter4.sv
// tb_counter4: directed self-checking bench for counter4 (default width) plus a MAX_VAL=9 instance.
module tb_counter4;
   logic clk = 1'b0, rst = 1'b0, en = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
   logic [3:0] load_val = '0, out;
   logic tc, wrap;
   logic en9 = 1'b0, load9 = 1'b0;
   logic [3:0] load_val9 = '0, out9;
   logic tc9, wrap9;
   int n_cmp = 0, n_err = 0;
   int held;

   counter4 dut (.clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
                 .load_val(load_val), .out(out), .tc(tc), .wrap(wrap));
   counter4 #(.WIDTH(4), .MAX_VAL(9)) dut9 (.clk(clk), .rst(rst), .en(en9), .dir(1'b0), .clr(1'b0),
                 .load(load9), .load_val(load_val9), .out(out9), .tc(tc9), .wrap(wrap9));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b1; dir = 1'b0;
      tick(); tick();
      n_cmp++; if (out !== 4'd0) begin n_err++; $display("FAIL reset_out got %0d want 0", out); end
      n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap got %b want 0", wrap); end
      n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc got %b want 0", tc); end
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_cmp++; if (out !== 4'(i)) begin n_err++; $display("FAIL release_out step %0d got %0d want %0d", i, out, i); end
      end
   endtask

   task automatic test_up_wrap;
      int exp;
      rst = 1'b1; tick(); rst = 1'b0; en = 1'b1; dir = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
`ifdef COUNTER4_SATURATE_EN
         exp = (i > 15) ? 15 : i;
`else
         exp = i % 16;
`endif
         n_cmp++; if (out !== 4'(exp)) begin n_err++; $display("FAIL up_out step %0d got %0d want %0d", i, out, exp); end
         n_cmp++; if (tc !== (exp == 15)) begin n_err++; $display("FAIL up_tc step %0d got %b want %b", i, tc, exp == 15); end
`ifdef COUNTER4_SATURATE_EN
         n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL up_wrap step %0d got %b want 0", i, wrap); end
`else
         n_cmp++; if (wrap !== (i == 16)) begin n_err++; $display("FAIL up_wrap step %0d got %b want %b", i, wrap, i == 16); end
`endif
      end
   endtask

   task automatic test_reset_mid;
      rst = 1'b1; tick(); rst = 1'b0; en = 1'b1; dir = 1'b0;
      repeat (9) tick();
      n_cmp++; if (out !== 4'd9) begin n_err++; $display("FAIL mid_pre got %0d want 9", out); end
      rst = 1'b1;
      tick();
      n_cmp++; if (out !== 4'd0) begin n_err++; $display("FAIL mid_rst got %0d want 0", out); end
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_cmp++; if (out !== 4'(i)) begin n_err++; $display("FAIL mid_resume step %0d got %0d want %0d", i, out, i); end
      end
   endtask

   task automatic test_down_load;
      int exp_seq[5];
      en = 1'b0; load = 1'b1; load_val = 4'd3;
      tick();
      load = 1'b0;
      n_cmp++; if (out !== 4'd3) begin n_err++; $display("FAIL load_out got %0d want 3", out); end
      n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL load_wrap got %b want 0", wrap); end
`ifdef COUNTER4_SATURATE_EN
      exp_seq = '{2, 1, 0, 0, 0};
`else
      exp_seq = '{2, 1, 0, 15, 14};
`endif
      dir = 1'b1; en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++; if (out !== 4'(exp_seq[i])) begin n_err++; $display("FAIL down_out step %0d got %0d want %0d", i, out, exp_seq[i]); end
         n_cmp++; if (tc !== (exp_seq[i] == 0)) begin n_err++; $display("FAIL down_tc step %0d got %b want %b", i, tc, exp_seq[i] == 0); end
`ifdef COUNTER4_SATURATE_EN
         n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL down_wrap step %0d got %b want 0", i, wrap); end
`else
         n_cmp++; if (wrap !== (i == 3)) begin n_err++; $display("FAIL down_wrap step %0d got %b want %b", i, wrap, i == 3); end
`endif
      end
      held = exp_seq[4];
   endtask

   task automatic test_priority;
      en = 1'b0;
      repeat (3) tick();
      n_cmp++; if (out !== 4'(held)) begin n_err++; $display("FAIL hold_out got %0d want %0d", out, held); end
      n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL hold_wrap got %b want 0", wrap); end
      clr = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1;
      tick();
      n_cmp++; if (out !== 4'd0) begin n_err++; $display("FAIL clr_over_load got %0d want 0", out); end
      clr = 1'b0; dir = 1'b0;
      tick();
      n_cmp++; if (out !== 4'd7) begin n_err++; $display("FAIL load_over_en got %0d want 7", out); end
      load = 1'b0;
      tick();
      n_cmp++; if (out !== 4'd8) begin n_err++; $display("FAIL dir_up got %0d want 8", out); end
      dir = 1'b1;
      tick();
      n_cmp++; if (out !== 4'd7) begin n_err++; $display("FAIL dir_change got %0d want 7", out); end
      en = 1'b0;
   endtask

   task automatic test_max9;
      int exp;
      rst = 1'b1; tick(); rst = 1'b0; en9 = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         tick();
`ifdef COUNTER4_SATURATE_EN
         exp = (i > 9) ? 9 : i;
         n_cmp++; if (wrap9 !== 1'b0) begin n_err++; $display("FAIL m9_wrap step %0d got %b want 0", i, wrap9); end
`else
         exp = i % 10;
         n_cmp++; if (wrap9 !== (i == 10)) begin n_err++; $display("FAIL m9_wrap step %0d got %b want %b", i, wrap9, i == 10); end
`endif
         n_cmp++; if (out9 !== 4'(exp)) begin n_err++; $display("FAIL m9_out step %0d got %0d want %0d", i, out9, exp); end
         n_cmp++; if (tc9 !== (exp == 9)) begin n_err++; $display("FAIL m9_tc step %0d got %b want %b", i, tc9, exp == 9); end
      end
      en9 = 1'b0; load9 = 1'b1; load_val9 = 4'd12;
      tick();
      load9 = 1'b0;
      n_cmp++; if (out9 !== 4'd9) begin n_err++; $display("FAIL m9_clamp got %0d want 9", out9); end
      n_cmp++; if (tc9 !== 1'b1) begin n_err++; $display("FAIL m9_clamp_tc got %b want 1", tc9); end
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_reset_mid();
      test_down_load();
      test_priority();
      test_max9();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/counter4.md
Name: counter4

Overview:
- Parameterized synchronous binary up/down counter; default 4-bit, free-running 0..15 with wrap.
- Used as a basic timing/sequencing primitive and as the board-level bring-up counter whose output drives LEDs/debug pins.
- Adds enable, synchronous clear, parallel load, direction control and terminal-count/wrap flags.

Parameters:
- WIDTH, 4, counter width in bits (legal 1..32).
- MAX_VAL, 2**WIDTH-1, highest count value; counter range is 0..MAX_VAL (modulo MAX_VAL+1). Must be 1..2**WIDTH-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; counter advances one step per clk while high.
- dir  input  1  count direction: 0 = up, 1 = down.
- clr  input  1  synchronous clear to 0, active-high.
- load  input  1  synchronous parallel load, active-high.
- load_val  input  WIDTH  value loaded when load=1.
- out  output  WIDTH  current count, registered.
- tc  output  1  terminal count flag, combinational from out and dir.
- wrap  output  1  registered one-cycle pulse marking a wrap event.

Behaviour:
- One clock domain, reset is synchronous and active-high; no asynchronous paths.
- Reset values: out = 0, wrap = 0; tc follows out (tc = 1 when dir = 1, i.e. out = 0 in down mode).
- Per rising edge, priority rst > clr > load > en:
  - rst: out <= 0, wrap <= 0.
  - clr: out <= 0, wrap <= 0.
  - load: out <= load_val, wrap <= 0. If load_val > MAX_VAL, out <= MAX_VAL (clamped).
  - en & dir=0: out <= (out == MAX_VAL) ? 0 : out+1.
  - en & dir=1: out <= (out == 0) ? MAX_VAL : out-1.
  - otherwise: out holds, wrap <= 0.
- Latency: out changes on the first rising edge where the controlling input is sampled high. Count starts on the first edge after rst deasserts.
- tc = (dir=0 & out==MAX_VAL) | (dir=1 & out==0); purely combinational.
- wrap = 1 for exactly the cycle after an enabled step that crossed MAX_VAL->0 (up) or 0->MAX_VAL (down); 0 otherwise.
- Direction change takes effect on the next enabled edge; no extra cycle is inserted.
- Reset or clear mid-count: out = 0 on that edge. Counting resumes from 0 on the first edge with rst=clr=0 and en=1.
- Any out value above MAX_VAL is unreachable.

Optional Feature:
- Macro: COUNTER4_SATURATE_EN.
- Defined: no wrap. Up mode holds at MAX_VAL and down mode holds at 0 while en=1. wrap is tied to 0. tc behaviour is unchanged.
- Undefined (default): modulo wrap-around as specified above.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1 -> out=0, wrap=0; release -> out = 1,2,3... on successive edges.
- Up wrap: en=1, dir=0 for 20 cycles after reset -> out 1..15, then 0, then 1..4; tc=1 while out=15; wrap=1 for only the cycle out=0.
- Reset mid-count: at out=9 assert rst 2 cycles -> out=0; release -> 1,2,3...
- Down/load: load=1, load_val=3, then dir=1 for 5 cycles -> 3,2,1,0,15,14; wrap pulses at 15; tc=1 at 0.
- Priority/hold: en=0 -> out holds. clr=1 & load=1 (load_val=7) -> 0. load=1 & en=1 -> load_val wins.
- MAX_VAL=9 build: up count -> 0..9,0. With COUNTER4_SATURATE_EN -> holds at 9, wrap stays 0.
